// File: rtl/eth_frame_buf_ctrl.sv
// -----------------------------------------------------------------------------
// eth_frame_buf_ctrl
//
// Store-and-forward frame buffer controller. Sequences an external
// single-clock dual-port byte RAM (registered read address, one-cycle read
// latency, synchronous write). Bytes arrive from the RGMII receive path with
// no backpressure. Good frames are committed whole. Errored or overflowing
// frames are discarded by rewinding the write pointer to the frame start.
// Committed frames are replayed on a valid/ready byte stream.
//
// Optional build macro: FRAME_BUF_STATS_EN adds saturating commit/discard
// counters (stat_frames_ok, stat_frames_drop).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_err receive byte stream (in_err with in_last)
//   out_valid/out_ready/out_data/out_last  replay stream (out_data = ram_q)
//   ram_wren/ram_wraddress/ram_data RAM write port
//   ram_rdaddress/ram_q             RAM read port (1-cycle latency)
//   frame_count                     committed frames not yet fully read
//   drop_pulse                      one-cycle pulse per discarded frame
//   stat_frames_ok/stat_frames_drop (FRAME_BUF_STATS_EN only)
// -----------------------------------------------------------------------------
module eth_frame_buf_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_last,
    input  logic                        in_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    output logic                        ram_wren,
    output logic [ADDR_WIDTH-1:0]       ram_wraddress,
    output logic [DATA_WIDTH-1:0]       ram_data,
    output logic [ADDR_WIDTH-1:0]       ram_rdaddress,
    input  logic [DATA_WIDTH-1:0]       ram_q,
    output logic [$clog2(LEN_DEPTH):0]  frame_count,
    output logic                        drop_pulse
`ifdef FRAME_BUF_STATS_EN
    ,
    output logic [31:0]                 stat_frames_ok,
    output logic [31:0]                 stat_frames_drop
`endif
);

    localparam int FC_W = $clog2(LEN_DEPTH) + 1;
    localparam int QA_W = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] A_TWO = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } rd_state_t;

    rd_state_t state;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] wr_start;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_rem;
    logic [ADDR_WIDTH-1:0] occupancy;
    logic [ADDR_WIDTH-1:0] frame_len;
    logic                  dropping;
    logic                  full;

    logic [ADDR_WIDTH-1:0] len_mem [LEN_DEPTH];
    logic [QA_W-1:0]       q_wr_idx;
    logic [QA_W-1:0]       q_rd_idx;
    logic [FC_W-1:0]       q_count;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_pop;

    logic                  frame_end;
    logic                  frame_bad;
    logic                  commit;
    logic                  discard;
    logic                  handshake;
    logic                  final_hs;

    function automatic logic [QA_W-1:0] next_idx(input logic [QA_W-1:0] i);
        if (i == QA_W'(LEN_DEPTH - 1))
            return '0;
        else
            return i + QA_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Combinational write path and frame-end decision
    // ------------------------------------------------------------------
    // Occupancy counts uncommitted bytes of the frame in flight too, so a
    // frame that is being received can never overwrite unread data.
    assign occupancy     = wr_ptr - rd_ptr;
    assign full          = (occupancy == '1);
    assign ram_wren      = in_valid & ~dropping & ~full;
    assign ram_wraddress = wr_ptr;
    assign ram_data      = in_data;

    assign q_full    = (q_count == FC_W'(LEN_DEPTH));
    assign q_empty   = (q_count == '0);
    assign frame_end = in_valid & in_last;
    assign frame_bad = dropping | in_err | full | q_full;
    assign commit    = frame_end & ~frame_bad;
    assign discard   = frame_end & frame_bad;
    // On commit the last byte is being written this cycle, hence the +1.
    assign frame_len = wr_ptr - wr_start + A_ONE;

    assign q_pop     = (state == IDLE) & ~q_empty;
    assign handshake = out_valid & out_ready;
    assign final_hs  = handshake & out_last;

    assign out_data  = ram_q;
    // Advancing the read address on the handshake keeps the next byte on
    // ram_q one cycle later; otherwise the current byte is re-read and held.
    assign ram_rdaddress = handshake ? (rd_ptr + A_ONE) : rd_ptr;

    // ------------------------------------------------------------------
    // Write pointer, frame start and discard control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            wr_start   <= '0;
            dropping   <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= discard;
            if (ram_wren)
                wr_ptr <= wr_ptr + A_ONE;
            if (frame_end) begin
                dropping <= 1'b0;
                // Rewind overrides the increment above for a bad frame.
                if (frame_bad)
                    wr_ptr <= wr_start;
                else
                    wr_start <= wr_ptr + A_ONE;
            end else if (in_valid && full) begin
                dropping <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Committed-frame length queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (commit)
            len_mem[q_wr_idx] <= frame_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_wr_idx <= '0;
            q_rd_idx <= '0;
            q_count  <= '0;
        end else begin
            if (commit)
                q_wr_idx <= next_idx(q_wr_idx);
            if (q_pop)
                q_rd_idx <= next_idx(q_rd_idx);
            q_count <= q_count + FC_W'(commit) - FC_W'(q_pop);
        end
    end

    // ------------------------------------------------------------------
    // Read sequencer: IDLE -> FETCH -> STREAM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            rd_rem    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (!q_empty) begin
                        rd_rem <= len_mem[q_rd_idx];
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    // ram_q carries the first byte from the next cycle on.
                    state     <= STREAM;
                    out_valid <= 1'b1;
                    out_last  <= (rd_rem == A_ONE);
                end
                STREAM: begin
                    if (out_ready) begin
                        rd_ptr <= rd_ptr + A_ONE;
                        rd_rem <= rd_rem - A_ONE;
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_last <= (rd_rem == A_TWO);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Committed frames outstanding (commit and final handshake net out)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_count <= '0;
        else
            frame_count <= frame_count + FC_W'(commit) - FC_W'(final_hs);
    end

`ifdef FRAME_BUF_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_ok   <= '0;
            stat_frames_drop <= '0;
        end else begin
            if (commit)
                stat_frames_ok <= sat_inc(stat_frames_ok);
            if (discard)
                stat_frames_drop <= sat_inc(stat_frames_drop);
        end
    end
`endif

endmodule

// File: tb/tb_eth_frame_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_frame_buf_ctrl
//
// Drives eth_frame_buf_ctrl (ADDR_WIDTH=8, LEN_DEPTH=4) with directed and
// randomized frames. An external RAM model is attached. A frame-level
// reference model (byte queues, occupancy and frame counters) predicts the
// outputs, and one process compares them on every cycle out of reset.
// -----------------------------------------------------------------------------
module tb_eth_frame_buf_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int LD    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int CAP   = DEPTH - 1;
    localparam int FCW   = $clog2(LD) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_err = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          ram_wren;
    logic [AW-1:0] ram_wraddress;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic [DW-1:0] ram_q;
    logic [FCW-1:0] frame_count;
    logic          drop_pulse;
`ifdef FRAME_BUF_STATS_EN
    logic [31:0]   stat_frames_ok;
    logic [31:0]   stat_frames_drop;
`endif

    always #5 clk = ~clk;

    eth_frame_buf_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_DEPTH (LD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_err       (in_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .ram_wren     (ram_wren),
        .ram_wraddress(ram_wraddress),
        .ram_data     (ram_data),
        .ram_rdaddress(ram_rdaddress),
        .ram_q        (ram_q),
        .frame_count  (frame_count),
        .drop_pulse   (drop_pulse)
`ifdef FRAME_BUF_STATS_EN
        ,
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_drop(stat_frames_drop)
`endif
    );

    // External RAM: synchronous write, registered read address.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_addr_q;
    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_wraddress] <= ram_data;
        rd_addr_q <= ram_rdaddress;
    end
    assign ram_q = mem[rd_addr_q];

    // ---------------- check bookkeeping ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] bytesq[$];   // committed, unread bytes in order
    logic [DW-1:0] cur[$];      // bytes of the frame being received
    int            lenq[$];     // committed lengths not yet taken by reader
    int  occ, fc, rphase, rem, mwp, mws, m_commits, m_drops;
    bit  m_dropping, m_drop_next;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytesq.delete(); cur.delete(); lenq.delete();
            occ = 0; fc = 0; rphase = 0; rem = 0; mwp = 0; mws = 0;
            m_commits = 0; m_drops = 0; m_dropping = 0; m_drop_next = 0;
        end else begin
            bit full_b, qfull_b;
            full_b  = (occ == CAP);
            qfull_b = (lenq.size() == LD);
            // reader: wait one cycle after taking a length, then stream
            if (rphase == 2) begin
                if (out_ready) begin
                    void'(bytesq.pop_front());
                    occ--; rem--;
                    if (rem == 0) begin rphase = 0; fc--; end
                end
            end else if (rphase == 1) begin
                rphase = 2;
            end else if (lenq.size() > 0) begin
                rem = lenq.pop_front();
                rphase = 1;
            end
            // writer
            m_drop_next = 0;
            if (in_valid) begin
                if (!m_dropping && !full_b) begin
                    cur.push_back(in_data);
                    occ++;
                    mwp = (mwp + 1) % DEPTH;
                end
                if (in_last) begin
                    if (m_dropping || in_err || full_b || qfull_b) begin
                        occ -= cur.size();
                        mwp = mws;
                        m_drop_next = 1;
                        m_drops++;
                    end else begin
                        foreach (cur[i]) bytesq.push_back(cur[i]);
                        lenq.push_back(cur.size());
                        fc++;
                        m_commits++;
                        mws = mwp;
                    end
                    cur.delete();
                    m_dropping = 0;
                end else if (full_b) begin
                    m_dropping = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit            check_en = 0;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            hs_cnt = 0, last_cnt = 0, drop_cnt = 0, wren_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else if (check_en) begin
            bit exp_valid, exp_wren;
            exp_valid = (rphase == 2);
            exp_wren  = in_valid && !m_dropping && (occ != CAP);
            chk("out_valid", out_valid, exp_valid);
            chk("ram_wren", ram_wren, exp_wren);
            chk("ram_wraddress", ram_wraddress, mwp);
            chk("frame_count", frame_count, fc);
            chk("drop_pulse", drop_pulse, m_drop_next);
            if (exp_valid) begin
                chk("out_data", out_data, bytesq.size() > 0 ? bytesq[0] : 0);
                chk("out_last", out_last, rem == 1);
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
`ifdef FRAME_BUF_STATS_EN
            chk("stat_ok", stat_frames_ok, m_commits);
            chk("stat_drop", stat_frames_drop, m_drops);
`endif
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (out_last) last_cnt++;
            end
            if (drop_pulse) drop_cnt++;
            if (ram_wren) wren_cnt++;
        end
    end

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;   // 0 low, 1 high, 2 random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int len, input bit err, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_last  = (i == len - 1);
            in_err   = err && (i == len - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((bytesq.size() > 0 || lenq.size() > 0 || rphase != 0) && n < bound) begin
            @(posedge clk); n++;
        end
        #1;
        chk("drain_in_time", n < bound, 1);
    endtask

    initial begin
        int hs0, last0, drop0, wren0;

        // reset state
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_ram_wraddress", ram_wraddress, 0);
        chk("rst_ram_rdaddress", ram_rdaddress, 0);
        rst_n = 1'b1;
        check_en = 1;
        idle(2);

        // 64-byte good frame with out_ready high
        ready_mode = 1;
        idle(2);
        hs0 = hs_cnt; last0 = last_cnt;
        send_frame(64, 0, 0);
        // now just after the commit edge
        chk("t64_fc_after_commit", frame_count, 1);
        chk("t64_valid_c0", out_valid, 0);
        idle(1);
        chk("t64_valid_c1", out_valid, 0);
        idle(1);
        chk("t64_valid_c2", out_valid, 1);
        wait_drain(500);
        idle(1);
        chk("t64_bytes", hs_cnt - hs0, 64);
        chk("t64_lasts", last_cnt - last0, 1);
        chk("t64_fc_end", frame_count, 0);

        // errored frame discarded, then 10-byte frame
        chk("err_wp_before", ram_wraddress, 64);
        hs0 = hs_cnt; last0 = last_cnt; drop0 = drop_cnt;
        send_frame(30, 1, 0);
        idle(2);
        chk("err_wp_restored", ram_wraddress, 64);
        chk("err_drops", drop_cnt - drop0, 1);
        send_frame(10, 0, 0);
        wait_drain(500);
        idle(1);
        chk("err_bytes", hs_cnt - hs0, 10);
        chk("err_wp_after", ram_wraddress, 74);

        // overflow: 270-byte frame into an empty 255-byte buffer
        ready_mode = 0;
        idle(2);
        wren0 = wren_cnt; drop0 = drop_cnt; hs0 = hs_cnt;
        send_frame(270, 0, 0);
        idle(2);
        chk("ovf_wren_count", wren_cnt - wren0, CAP);
        chk("ovf_drops", drop_cnt - drop0, 1);
        chk("ovf_wp_restored", ram_wraddress, 74);
        send_frame(20, 0, 0);
        idle(4);
        chk("ovf_fc_held", frame_count, 1);
        ready_mode = 1;
        wait_drain(500);
        idle(1);
        chk("ovf_bytes", hs_cnt - hs0, 20);

        // single-byte frames with out_ready low: the reader holds the first,
        // four fill the length queue, the sixth is discarded
        ready_mode = 0;
        idle(2);
        hs0 = hs_cnt; last0 = last_cnt; drop0 = drop_cnt;
        send_frame(1, 0, 0);
        send_frame(1, 0, 0);
        send_frame(1, 0, 0);
        send_frame(1, 0, 0);
        send_frame(1, 0, 0);
        send_frame(1, 0, 0);
        idle(3);
        chk("q_fc_full", frame_count, 5);
        chk("q_drops", drop_cnt - drop0, 1);
        ready_mode = 1;
        wait_drain(500);
        idle(1);
        chk("q_bytes", hs_cnt - hs0, 5);
        chk("q_lasts", last_cnt - last0, 5);
        chk("q_wp", ram_wraddress, 99);

        // 200-byte frame across the address wrap, random out_ready
        ready_mode = 2;
        hs0 = hs_cnt; last0 = last_cnt;
        send_frame(200, 0, 0);
        wait_drain(2000);
        idle(1);
        chk("wrap_bytes", hs_cnt - hs0, 200);
        chk("wrap_lasts", last_cnt - last0, 1);
        chk("wrap_wp", ram_wraddress, (99 + 200) % DEPTH);

        // random frames, gaps, errors and out_ready
        for (int f = 0; f < 16; f++) begin
            send_frame($urandom_range(1, 90), $urandom_range(5) == 0, 20);
            idle($urandom_range(3));
        end
        ready_mode = 1;
        wait_drain(3000);

        // reset in the middle of streaming
        send_frame(50, 0, 0);
        idle(5);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_out_last", out_last, 0);
        idle(3);
        rst_n = 1'b1;
        hs0 = hs_cnt;
        idle(20);
        chk("midrst_no_residue", hs_cnt - hs0, 0);
        chk("midrst_fc_after", frame_count, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
